// File: rtl/round_timer_pkg.sv
// Shared types and constants for the round timer: FSM state encoding,
// BCD digit type, and the clamp-to-BCD conversion used on duration writes.
package round_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam int MAX_SECS = 99;

    // Returns {tens, ones}; a zero duration becomes 1 s and anything above 99 becomes 99 s.
    function automatic logic [7:0] clamp_to_bcd(input logic [6:0] secs);
        logic [6:0] c;
        if (secs == 7'd0) begin
            c = 7'd1;
        end else if (secs > 7'(MAX_SECS)) begin
            c = 7'(MAX_SECS);
        end else begin
            c = secs;
        end
        return {4'(c / 7'd10), 4'(c % 7'd10)};
    endfunction

endpackage

// File: rtl/round_timer_ctrl_if.sv
// Configuration bus of the round timer: duration write and count reload.
// Plain pulse interface with no ready: each pulse is accepted in the cycle it is high.
interface round_timer_ctrl_if;
    logic [6:0] Dur_In;
    logic       Dur_Wr;
    logic       Time_Reconfig;

    modport master (output Dur_In, Dur_Wr, Time_Reconfig);
    modport slave  (input  Dur_In, Dur_Wr, Time_Reconfig);
endinterface

// File: rtl/round_timer_ctrl_prescaler.sv
// One-second prescaler: counts 0..CLK_HZ-1 while run is high, holds otherwise,
// and flags the cycle whose edge wraps the counter back to 0.
module tick_prescaler #(
    parameter int CLK_HZ = 50000000
) (
    input  logic Clk,
    input  logic Rst,
    input  logic i_run,
    input  logic i_clear,
    output logic o_wrap
);
    localparam int CW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_at_top;

    assign w_at_top = (r_cnt == CW'(CLK_HZ - 1));
    assign o_wrap   = i_run && w_at_top && !i_clear;

    always_ff @(posedge Clk) begin
        if (!Rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= w_at_top ? '0 : r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/round_timer_ctrl.sv
// Round countdown timer with BCD seconds display, pause/resume and expiry.
// Optional low-time warning output is built only when ROUND_TIMER_WARN_EN is defined.
module round_timer_ctrl
    import round_timer_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int DEF_SECS  = 60,
    parameter int WARN_SECS = 10
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Timer_En,
    round_timer_ctrl_if.slave        cfg,
    output logic                     Time_Out,
    output logic                     Tick,
    output bcd_digit_t               Secs_Tens,
    output bcd_digit_t               Secs_Ones,
    output logic                     Timer_Warn,
    output state_t                   o_dbg_state
);
    if (CLK_HZ < 2) begin : g_bad_clk_hz
        $error("CLK_HZ must be at least 2");
    end
    if (DEF_SECS < 1 || DEF_SECS > MAX_SECS || WARN_SECS < 1 || WARN_SECS > MAX_SECS) begin : g_bad_secs
        $error("DEF_SECS and WARN_SECS must lie in 1..99");
    end

    localparam logic [7:0] DEF_BCD = {4'(DEF_SECS / 10), 4'(DEF_SECS % 10)};

    state_t     r_state, w_next_state;
    logic [7:0] r_cfg;
    bcd_digit_t r_tens, r_ones, w_next_tens, w_next_ones;
    logic       r_time_out, r_tick;
    logic       w_run, w_wrap, w_last;
    logic [7:0] w_clamped;

    // The cycle in which Timer_En is first seen already counts toward the first second.
    assign w_run     = Timer_En && (r_state != EXPIRED) && !cfg.Time_Reconfig;
    assign w_last    = (r_tens == 4'd0) && (r_ones == 4'd1);
    assign w_clamped = clamp_to_bcd(cfg.Dur_In);

    tick_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
        .Clk     (Clk),
        .Rst     (Rst),
        .i_run   (w_run),
        .i_clear (cfg.Time_Reconfig),
        .o_wrap  (w_wrap)
    );

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (Timer_En) w_next_state = RUN;
            RUN:     if (w_wrap && w_last) w_next_state = EXPIRED;
                     else if (!Timer_En) w_next_state = PAUSE;
            PAUSE:   if (w_wrap && w_last) w_next_state = EXPIRED;
                     else if (Timer_En) w_next_state = RUN;
            EXPIRED: w_next_state = EXPIRED;
            default: w_next_state = IDLE;
        endcase
        if (cfg.Time_Reconfig) w_next_state = IDLE;
    end

    always_comb begin
        w_next_tens = r_tens;
        w_next_ones = r_ones;
        if (cfg.Time_Reconfig) begin
            {w_next_tens, w_next_ones} = cfg.Dur_Wr ? w_clamped : r_cfg;
        end else if (w_wrap) begin
            w_next_ones = (r_ones == 4'd0) ? 4'd9 : r_ones - 4'd1;
            w_next_tens = (r_ones == 4'd0) ? r_tens - 4'd1 : r_tens;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_cfg      <= DEF_BCD;
            r_tens     <= DEF_BCD[7:4];
            r_ones     <= DEF_BCD[3:0];
            r_time_out <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_tick <= w_wrap;
            r_tens <= w_next_tens;
            r_ones <= w_next_ones;
            if (cfg.Dur_Wr) r_cfg <= w_clamped;
            if (cfg.Time_Reconfig) begin
                r_time_out <= 1'b0;
            end else if (w_wrap && w_last) begin
                r_time_out <= 1'b1;
            end
        end
    end

`ifdef ROUND_TIMER_WARN_EN
    logic       r_warn;
    logic [6:0] w_next_secs;

    assign w_next_secs = 7'(w_next_tens) * 7'd10 + 7'(w_next_ones);

    // Evaluated on next-state values so the warning lines up with the digits it describes.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_warn <= 1'b0;
        end else begin
            r_warn <= ((w_next_state == RUN) || (w_next_state == PAUSE)) &&
                      (w_next_secs != 7'd0) && (w_next_secs <= 7'(WARN_SECS));
        end
    end
    assign Timer_Warn = r_warn;
`else
    assign Timer_Warn = 1'b0;
`endif

    assign Time_Out    = r_time_out;
    assign Tick        = r_tick;
    assign Secs_Tens   = r_tens;
    assign Secs_Ones   = r_ones;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_round_timer_ctrl.sv
// Directed bench for round_timer_ctrl with CLK_HZ=4: expected digits are queued
// ahead of each Tick and compared when the Tick is observed.
module tb_round_timer_ctrl;
    import round_timer_pkg::*;

    localparam int CLK_HZ    = 4;
    localparam int DEF_SECS  = 60;
    localparam int WARN_SECS = 10;
`ifdef ROUND_TIMER_WARN_EN
    localparam logic [31:0] WARN_ON = 32'd1;
`else
    localparam logic [31:0] WARN_ON = 32'd0;
`endif

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Timer_En;
    logic       Time_Out, Tick, Timer_Warn;
    bcd_digit_t Secs_Tens, Secs_Ones;
    state_t     dbg_state;

    round_timer_ctrl_if cfg_if ();

    int         n_tests    = 0;
    int         n_fail     = 0;
    int         tick_count = 0;
    logic [7:0] exp_q[$];

    always #5 Clk = ~Clk;

    round_timer_ctrl #(
        .CLK_HZ    (CLK_HZ),
        .DEF_SECS  (DEF_SECS),
        .WARN_SECS (WARN_SECS)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Timer_En    (Timer_En),
        .cfg         (cfg_if),
        .Time_Out    (Time_Out),
        .Tick        (Tick),
        .Secs_Tens   (Secs_Tens),
        .Secs_Ones   (Secs_Ones),
        .Timer_Warn  (Timer_Warn),
        .o_dbg_state (dbg_state)
    );

    function automatic void check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    function automatic logic [31:0] digits();
        return 32'({Secs_Tens, Secs_Ones});
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
        #1;
    endtask

    // Scoreboard: every Tick must have a queued expectation for the digits it shows.
    always @(negedge Clk) begin
        if (Tick === 1'b1) begin
            tick_count++;
            check("tick_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("tick_digits", digits(), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b0;
        Timer_En = 1'b0;
        cfg_if.Dur_In = 7'd0;
        cfg_if.Dur_Wr = 1'b0;
        cfg_if.Time_Reconfig = 1'b0;
        cyc(3);
        Rst = 1'b1;
        check("rst_digits", digits(), 32'h60);
        check("rst_timeout", 32'(Time_Out), 32'd0);
        check("rst_tick", 32'(Tick), 32'd0);
        check("rst_warn", 32'(Timer_Warn), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));

        // Eight enabled cycles give two one-second ticks.
        exp_q.push_back(8'h59);
        exp_q.push_back(8'h58);
        Timer_En = 1'b1;
        cyc(8);
        Timer_En = 1'b0;
        check("run8_ticks", 32'(tick_count), 32'd2);
        check("run8_digits", digits(), 32'h58);
        check("run8_timeout", 32'(Time_Out), 32'd0);
        cyc(1);
        check("pause_state", 32'(dbg_state), 32'(PAUSE));

        // Duration write alone leaves the count; reload then run to expiry.
        cfg_if.Dur_In = 7'd3;
        cfg_if.Dur_Wr = 1'b1;
        cyc(1);
        cfg_if.Dur_Wr = 1'b0;
        check("wr_no_effect", digits(), 32'h58);
        cfg_if.Time_Reconfig = 1'b1;
        cyc(1);
        cfg_if.Time_Reconfig = 1'b0;
        check("reload3_digits", digits(), 32'h03);
        check("reload3_state", 32'(dbg_state), 32'(IDLE));
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h00);
        Timer_En = 1'b1;
        cyc(11);
        check("pre_exp_digits", digits(), 32'h01);
        check("pre_exp_timeout", 32'(Time_Out), 32'd0);
        cyc(1);
        check("exp_digits", digits(), 32'h00);
        check("exp_timeout", 32'(Time_Out), 32'd1);
        check("exp_state", 32'(dbg_state), 32'(EXPIRED));
        check("exp_ticks", 32'(tick_count), 32'd5);
        cyc(20);
        check("exp_hold_timeout", 32'(Time_Out), 32'd1);
        check("exp_hold_digits", digits(), 32'h00);
        check("exp_hold_ticks", 32'(tick_count), 32'd5);

        // Write and reload on the same edge load the new value.
        cfg_if.Dur_In = 7'd11;
        cfg_if.Dur_Wr = 1'b1;
        cfg_if.Time_Reconfig = 1'b1;
        Timer_En = 1'b0;
        cyc(1);
        cfg_if.Dur_Wr = 1'b0;
        cfg_if.Time_Reconfig = 1'b0;
        check("wr_reload_digits", digits(), 32'h11);
        check("wr_reload_timeout", 32'(Time_Out), 32'd0);
        check("idle_warn", 32'(Timer_Warn), 32'd0);

        // Pause at 10 with the prescaler two cycles into a second.
        exp_q.push_back(8'h10);
        Timer_En = 1'b1;
        cyc(6);
        check("run10_digits", digits(), 32'h10);
        check("run10_warn", 32'(Timer_Warn), WARN_ON);
        Timer_En = 1'b0;
        cyc(9);
        check("pause_no_tick", 32'(tick_count), 32'd6);
        check("pause10_state", 32'(dbg_state), 32'(PAUSE));
        check("pause10_digits", digits(), 32'h10);
        check("pause10_warn", 32'(Timer_Warn), WARN_ON);
        exp_q.push_back(8'h09);
        Timer_En = 1'b1;
        cyc(1);
        check("resume_early", 32'(tick_count), 32'd6);
        cyc(1);
        check("resume_phase", 32'(tick_count), 32'd7);
        check("resume_digits", digits(), 32'h09);

        // Reload with Timer_En high mid-second: back to IDLE with the prescaler cleared.
        cyc(2);
        cfg_if.Time_Reconfig = 1'b1;
        cyc(1);
        cfg_if.Time_Reconfig = 1'b0;
        check("prio_state", 32'(dbg_state), 32'(IDLE));
        check("prio_digits", digits(), 32'h11);
        check("prio_tick", 32'(Tick), 32'd0);
        exp_q.push_back(8'h10);
        cyc(3);
        check("prio_presc_clear", 32'(tick_count), 32'd7);
        check("prio_run_state", 32'(dbg_state), 32'(RUN));
        cyc(1);
        check("prio_first_tick", 32'(tick_count), 32'd8);

        // Clamping of out-of-range durations, plus an in-range BCD conversion.
        Timer_En = 1'b0;
        cfg_if.Dur_In = 7'd0;
        cfg_if.Dur_Wr = 1'b1;
        cyc(1);
        cfg_if.Dur_Wr = 1'b0;
        check("clamp0_pending", digits(), 32'h10);
        cfg_if.Time_Reconfig = 1'b1;
        cyc(1);
        cfg_if.Time_Reconfig = 1'b0;
        check("clamp0_digits", digits(), 32'h01);
        cfg_if.Dur_In = 7'd120;
        cfg_if.Dur_Wr = 1'b1;
        cyc(1);
        cfg_if.Dur_Wr = 1'b0;
        cfg_if.Time_Reconfig = 1'b1;
        cyc(1);
        cfg_if.Time_Reconfig = 1'b0;
        check("clamp120_digits", digits(), 32'h99);
        cfg_if.Dur_In = 7'd42;
        cfg_if.Dur_Wr = 1'b1;
        cfg_if.Time_Reconfig = 1'b1;
        cyc(1);
        cfg_if.Dur_Wr = 1'b0;
        cfg_if.Time_Reconfig = 1'b0;
        check("bcd42_digits", digits(), 32'h42);

        // Reset on the edge that would have produced the first Tick.
        Rst = 1'b0;
        cyc(2);
        Rst = 1'b1;
        check("rst2_digits", digits(), 32'h60);
        Timer_En = 1'b1;
        cyc(3);
        Rst = 1'b0;
        cyc(1);
        check("rst_mid_ticks", 32'(tick_count), 32'd8);
        check("rst_mid_tick", 32'(Tick), 32'd0);
        check("rst_mid_digits", digits(), 32'h60);
        check("rst_mid_timeout", 32'(Time_Out), 32'd0);
        check("rst_mid_state", 32'(dbg_state), 32'(IDLE));
        Rst = 1'b1;
        Timer_En = 1'b0;
        cyc(4);
        check("rst_after_ticks", 32'(tick_count), 32'd8);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
